// File: rtl/muldiv_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_pkg
//   Shared types for the iterative RV32M multiply/divide unit.
//   - muldiv_op_t : M-extension operation, encoded exactly as funct3
//   - state_t     : sequencer states
//   - op_class_t  : per-op signedness/kind, derived once from the opcode
// -----------------------------------------------------------------------------
package muldiv_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic is_div;
        logic a_signed;
        logic b_signed;
    } op_class_t;

    // All divide/remainder ops share funct3[2] = 1.
    function automatic logic is_div_op(input muldiv_op_t op);
        return op[2];
    endfunction

    // MUL is treated as unsigned: its low product half is sign-independent.
    function automatic op_class_t classify_op(input muldiv_op_t op);
        op_class_t c;
        c.is_div   = is_div_op(op);
        c.a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        c.b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        return c;
    endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//   Iterative radix-2 RV32M multiply/divide unit beside the execute-stage ALU.
//   Operands are reduced to magnitudes on accept, iterated for XLEN cycles
//   (shift-add multiply or restoring divide in one shared 2*XLEN accumulator),
//   sign-corrected in FIX, and presented for exactly one cycle in DONE.
//
// Ports
//   clk_i            rising-edge clock
//   rst_i            synchronous, active-high reset
//   start_i          EX holds a valid M-extension instruction
//   op_i             muldiv_op_t (funct3)
//   operand_a_i      rs1 after forwarding
//   operand_b_i      rs2 after forwarding
//   flush_i          pipeline kill: abort the current op
//   stall_o          hold IF/ID/EX while the op is in flight
//   result_o         result, meaningful while result_valid_o = 1
//   result_valid_o   one-cycle pulse selecting result_o over the ALU result
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int XLEN       = 32,
    parameter bit ZERO_SHORT = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic [XLEN-1:0] result_o,
    output logic            result_valid_o
);
    import muldiv_sequencer_pkg::*;

    localparam int               CNT_W     = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;       // {high/remainder, low/multiplier/quotient}
    logic [XLEN-1:0]   opb_q, opb_d;       // |b|: multiplicand or divisor
    muldiv_op_t        op_q, op_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic              div_zero_q, div_zero_d;
    logic [XLEN-1:0]   result_q, result_d;

    // ---------------- incoming request ----------------
    muldiv_op_t      op_in;
    op_class_t       in_cls;
    logic            a_neg, b_neg, b_zero;
    logic [XLEN-1:0] a_mag, b_mag;

    assign op_in  = muldiv_op_t'(op_i);
    assign in_cls = classify_op(op_in);
    assign a_neg  = in_cls.a_signed & operand_a_i[XLEN-1];
    assign b_neg  = in_cls.b_signed & operand_b_i[XLEN-1];
    assign a_mag  = a_neg ? -operand_a_i : operand_a_i;
    assign b_mag  = b_neg ? -operand_b_i : operand_b_i;
    assign b_zero = (operand_b_i == '0);

    // ---------------- one iteration step ----------------
    // Multiply: add |b| into the high half when the current multiplier bit is
    // set, then shift the whole accumulator (with carry) right by one.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring divide: trial-subtract the divisor from the left-shifted
    // partial remainder; a non-negative difference commits and shifts in a 1.
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    assign div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
    assign div_next = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    // ---------------- sign correction ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        // A zero divisor yields all-ones regardless of the dividend's sign.
        quo_fix  = div_zero_q ? '1
                 : ((sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
        rem_fix  = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       fix_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_result = quo_fix;
            default:                      fix_result = rem_fix;
        endcase
    end

    // ---------------- next-state / outputs ----------------
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d        = state_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        opb_d          = opb_q;
        op_d           = op_q;
        sign_a_d       = sign_a_q;
        sign_b_d       = sign_b_q;
        div_zero_d     = div_zero_q;
        result_d       = result_q;
        stall_o        = 1'b0;
        result_valid_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !flush_i) begin
                    stall_o    = 1'b1;
                    op_d       = op_in;
                    sign_a_d   = a_neg;
                    sign_b_d   = b_neg;
                    acc_d      = {{XLEN{1'b0}}, a_mag};
                    opb_d      = b_mag;
                    cnt_d      = '0;
                    div_zero_d = in_cls.is_div & b_zero;
                    if (ZERO_SHORT && in_cls.is_div && b_zero) begin
                        // Quotient ops get all ones, remainder ops the raw dividend.
                        result_d = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : operand_a_i;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_CALC;
                    end
                end
            end

            ST_CALC: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    stall_o = 1'b1;
                    acc_d   = is_div_op(op_q) ? div_next : mul_next;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    stall_o  = 1'b1;
                    result_d = fix_result;
                    state_d  = ST_DONE;
                end
            end

            default: begin  // ST_DONE
                result_valid_o = ~flush_i;
                state_d        = ST_IDLE;
            end
        endcase
    end

    assign result_o = result_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            op_q       <= OP_MUL;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            result_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            op_q       <= op_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            div_zero_q <= div_zero_d;
            result_q   <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//   Directed and random checks of muldiv_sequencer (XLEN=32, ZERO_SHORT=1)
//   against an arithmetic reference model: results, latency, stall profile,
//   flush, reset and start/flush collision.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam int LAT_FULL = 34;

    localparam logic [2:0] MUL    = 3'd0;
    localparam logic [2:0] MULH   = 3'd1;
    localparam logic [2:0] MULHSU = 3'd2;
    localparam logic [2:0] MULHU  = 3'd3;
    localparam logic [2:0] DIV    = 3'd4;
    localparam logic [2:0] DIVU   = 3'd5;
    localparam logic [2:0] REM    = 3'd6;
    localparam logic [2:0] REMU   = 3'd7;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        flush;
    logic        stall;
    logic [31:0] res;
    logic        valid;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_sequencer #(.XLEN(32), .ZERO_SHORT(1'b1)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .op_i           (op),
        .operand_a_i    (opa),
        .operand_b_i    (opb),
        .flush_i        (flush),
        .stall_o        (stall),
        .result_o       (res),
        .result_valid_o (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: RV32M semantics via 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ub = longint'(b);
        logic [63:0] p;
        int          ia = a;
        int          ib = b;
        case (f3)
            MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0];  end
            MULH:   begin p = sa * sb;                 return p[63:32]; end
            MULHSU: begin p = sa * ub;                 return p[63:32]; end
            MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one op at a negedge and follow it cycle by cycle to its result.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int lat;
        lat = (f3[2] && b == 0) ? 1 : LAT_FULL;
        @(negedge clk);
        start = 1'b1; op = f3; opa = a; opb = b;
        #1 check({tag, " stall_t0"}, {31'b0, stall}, 32'd1);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k < lat) begin
                check({tag, " busy"}, {30'b0, stall, valid}, 32'd2);
            end else begin
                check({tag, " done_flags"}, {30'b0, stall, valid}, 32'd1);
                check({tag, " result"}, res, exp);
            end
            if (k == 1) begin
                // Operands must have been latched: scramble the bus.
                start = 1'b0; opa = $urandom; opb = $urandom; op = 3'($urandom);
            end
        end
        @(negedge clk);
        check({tag, " pulse_end"}, {31'b0, valid}, 32'd0);
    endtask

    initial begin
        int pulses;
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; opa = '0; opb = '0;
        repeat (2) @(negedge clk);
        check("reset stall", {31'b0, stall}, 32'd0);
        check("reset valid", {31'b0, valid}, 32'd0);
        check("reset result", res, 32'd0);
        rst = 1'b0;

        // Directed cases
        run_op(MUL,    32'd7,          32'd6,          32'h0000_002A, "mul_7x6");
        run_op(DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, "div_-7/2");
        run_op(REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, "rem_-7/2");
        run_op(REMU,   32'd7,          32'd2,          32'h0000_0001, "remu_7/2");
        run_op(MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, "mulhu_ff");
        run_op(MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, "mulh_ff");
        run_op(MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF, "mulhsu_-1x2");
        run_op(DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF, "divu_5/0");
        run_op(REM,    32'd5,          32'd0,          32'h0000_0005, "rem_5/0");
        run_op(DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, "div_ovf");
        run_op(REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, "rem_ovf");

        // Flush at T0+10, restart at T0+12
        @(negedge clk);
        start = 1'b1; op = MUL; opa = 32'd3; opb = 32'd5;
        #1 check("flush stall_t0", {31'b0, stall}, 32'd1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k < 10) check("flush busy", {30'b0, stall, valid}, 32'd2);
        end
        flush = 1'b1;
        #1 check("flush stall_drop", {30'b0, stall, valid}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        check("flush idle", {30'b0, stall, valid}, 32'd0);
        run_op(DIVU, 32'd100, 32'd7, 32'd14, "after_flush");

        // Reset at T0+5
        @(negedge clk);
        start = 1'b1; op = DIV; opa = 32'd1000; opb = 32'd3;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid stall", {31'b0, stall}, 32'd0);
        check("rst_mid valid", {31'b0, valid}, 32'd0);
        check("rst_mid result", res, 32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        check("rst_mid no_pulse", pulses, 32'd0);

        // start and flush together: not accepted
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = DIVU; opa = 32'd5; opb = 32'd0;
        #1 check("start_flush stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("start_flush idle", {31'b0, stall}, 32'd0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        check("start_flush no_pulse", pulses, 32'd0);

        // Random ops against the model
        for (int i = 0; i < 40; i++) begin
            r_op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0:       begin r_a = $urandom; r_b = 32'd0; end
                1:       begin r_a = 32'($urandom_range(0, 300)); r_b = 32'($urandom_range(1, 20)); end
                2:       begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                default: begin r_a = $urandom; r_b = $urandom; end
            endcase
            run_op(r_op, r_a, r_b, ref_model(r_op, r_a, r_b), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
